// File: rtl/adc_pkg.sv
// Shared widths and the ADC-code-to-sample conversion for the ADC sample packer.
package adc_pkg;

    localparam int ADC_WIDTH    = 14;
    localparam int SAMPLE_WIDTH = 16;
    localparam int NUM_CHANNELS = 4;
    localparam int BEAT_WIDTH   = SAMPLE_WIDTH * NUM_CHANNELS;

    // Offset binary becomes two's complement by flipping the MSB.
    function automatic logic [SAMPLE_WIDTH-1:0] adc_to_sample(
        input logic [ADC_WIDTH-1:0] code,
        input logic                 signed_out
    );
        logic [ADC_WIDTH-1:0] twos;
        twos = {~code[ADC_WIDTH-1], code[ADC_WIDTH-2:0]};
        if (signed_out)
            return {{(SAMPLE_WIDTH-ADC_WIDTH){twos[ADC_WIDTH-1]}}, twos};
        else
            return {{(SAMPLE_WIDTH-ADC_WIDTH){1'b0}}, code};
    endfunction

endpackage

// File: rtl/adc_sample_packer_if.sv
// AXI4-Stream beat bundle carrying packed ADC sample sets to the DMA engine.
interface adc_sample_packer_if;
    import adc_pkg::*;

    logic                  TVALID;
    logic                  TREADY;
    logic [BEAT_WIDTH-1:0] TDATA;
    logic                  TLAST;

    modport master (output TVALID, output TDATA, output TLAST, input TREADY);
    modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry an extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    // Head entry is presented combinationally; zero while empty.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Converts 4-channel ADC sample sets into 64-bit AXI-Stream beats framed every PACKET_LEN samples.
module adc_sample_packer
    import adc_pkg::*;
#(
    parameter int PACKET_LEN = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int SIGNED_OUT = 1
) (
    input  logic                          AXI_CLK,
    input  logic                          RESET_N,
    input  logic                          ENABLE,
    input  logic                          IN_DATA_VALID,
    input  logic [ADC_WIDTH-1:0]          IN_CH_1_DATA,
    input  logic [ADC_WIDTH-1:0]          IN_CH_2_DATA,
    input  logic [ADC_WIDTH-1:0]          IN_CH_3_DATA,
    input  logic [ADC_WIDTH-1:0]          IN_CH_4_DATA,
    adc_sample_packer_if.master           M_AXIS,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic [31:0]                   OVERFLOW_COUNT
);

    localparam int IDX_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

    logic                  accept;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  is_last;
    logic [IDX_W-1:0]      sample_idx;
    logic [BEAT_WIDTH-1:0] beat;
    logic [BEAT_WIDTH:0]   head;

    assign accept  = IN_DATA_VALID & ENABLE;
    assign push    = accept & ~fifo_full;
    assign is_last = (sample_idx == IDX_W'(PACKET_LEN - 1));

    assign beat = {adc_to_sample(IN_CH_4_DATA, SIGNED_OUT != 0),
                   adc_to_sample(IN_CH_3_DATA, SIGNED_OUT != 0),
                   adc_to_sample(IN_CH_2_DATA, SIGNED_OUT != 0),
                   adc_to_sample(IN_CH_1_DATA, SIGNED_OUT != 0)};

    sync_fifo #(
        .WIDTH (BEAT_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (AXI_CLK),
        .rst_n   (RESET_N),
        .push    (push),
        .wr_data ({is_last, beat}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (FIFO_LEVEL)
    );

    assign M_AXIS.TVALID = ~fifo_empty;
    assign M_AXIS.TDATA  = head[BEAT_WIDTH-1:0];
    assign M_AXIS.TLAST  = head[BEAT_WIDTH];
    assign pop           = ~fifo_empty & M_AXIS.TREADY;

    // Dropped samples leave the packet index alone so framing tracks accepted beats only.
    always_ff @(posedge AXI_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sample_idx     <= '0;
            OVERFLOW_COUNT <= '0;
        end else begin
            if (push)
                sample_idx <= is_last ? '0 : sample_idx + 1'b1;
            if (accept && fifo_full && (OVERFLOW_COUNT != 32'hFFFF_FFFF))
                OVERFLOW_COUNT <= OVERFLOW_COUNT + 32'd1;
        end
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer with PACKET_LEN = 4, FIFO_DEPTH = 8, signed output.
module tb_adc_sample_packer;
    import adc_pkg::*;

    localparam int PKT   = 4;
    localparam int DEPTH = 8;

    typedef struct {
        logic [13:0] c1;
        logic [13:0] c2;
        logic [13:0] c3;
        logic [13:0] c4;
        logic [63:0] expData;
        logic        expLast;
    } vec_t;

    logic        AXI_CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic        IN_DATA_VALID = 1'b0;
    logic [13:0] IN_CH_1_DATA = '0;
    logic [13:0] IN_CH_2_DATA = '0;
    logic [13:0] IN_CH_3_DATA = '0;
    logic [13:0] IN_CH_4_DATA = '0;
    logic [3:0]  FIFO_LEVEL;
    logic [31:0] OVERFLOW_COUNT;

    int compared   = 0;
    int mismatched = 0;

    vec_t vecs [8];

    adc_sample_packer_if axis ();

    adc_sample_packer #(
        .PACKET_LEN (PKT),
        .FIFO_DEPTH (DEPTH),
        .SIGNED_OUT (1)
    ) dut (
        .AXI_CLK        (AXI_CLK),
        .RESET_N        (RESET_N),
        .ENABLE         (ENABLE),
        .IN_DATA_VALID  (IN_DATA_VALID),
        .IN_CH_1_DATA   (IN_CH_1_DATA),
        .IN_CH_2_DATA   (IN_CH_2_DATA),
        .IN_CH_3_DATA   (IN_CH_3_DATA),
        .IN_CH_4_DATA   (IN_CH_4_DATA),
        .M_AXIS         (axis),
        .FIFO_LEVEL     (FIFO_LEVEL),
        .OVERFLOW_COUNT (OVERFLOW_COUNT)
    );

    always #5 AXI_CLK = ~AXI_CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge AXI_CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [13:0] a, input logic [13:0] b,
                                 input logic [13:0] c, input logic [13:0] d);
        IN_CH_1_DATA  = a;
        IN_CH_2_DATA  = b;
        IN_CH_3_DATA  = c;
        IN_CH_4_DATA  = d;
        IN_DATA_VALID = 1'b1;
        tick();
        IN_DATA_VALID = 1'b0;
    endtask

    // Sample with ch1 = k and the other channels at mid-scale converts to E000 | k on ch1 only.
    function automatic logic [63:0] rampData(input int k);
        return {48'h0, 16'hE000 | 16'(k)};
    endfunction

    task automatic sendAndCheck(input string name, input logic [13:0] a, input logic [13:0] b,
                                input logic [13:0] c, input logic [13:0] d,
                                input logic [63:0] expData, input logic expLast);
        checkOutput({name, " idle tvalid"}, 64'(axis.TVALID), 64'd0);
        applyStimulus(a, b, c, d);
        checkOutput({name, " tvalid"}, 64'(axis.TVALID), 64'd1);
        checkOutput({name, " tdata"}, axis.TDATA, expData);
        checkOutput({name, " tlast"}, 64'(axis.TLAST), 64'(expLast));
        tick();
        checkOutput({name, " popped"}, 64'(axis.TVALID), 64'd0);
    endtask

    initial begin
        vecs[0] = '{14'h2000, 14'h0000, 14'h3FFF, 14'h0001, 64'hE001_1FFF_E000_0000, 1'b0};
        vecs[1] = '{14'h1FFF, 14'h2001, 14'h3000, 14'h1000, 64'hF000_1000_0001_FFFF, 1'b0};
        vecs[2] = '{14'h2000, 14'h2000, 14'h2000, 14'h2000, 64'h0000_0000_0000_0000, 1'b0};
        vecs[3] = '{14'h0ABC, 14'h3ABC, 14'h2155, 14'h0155, 64'hE155_0155_1ABC_EABC, 1'b1};
        vecs[4] = '{14'h0001, 14'h0002, 14'h0003, 14'h0004, 64'hE004_E003_E002_E001, 1'b0};
        vecs[5] = '{14'h3FFE, 14'h2002, 14'h1234, 14'h2345, 64'h0345_F234_0002_1FFE, 1'b0};
        vecs[6] = '{14'h3333, 14'h0CCC, 14'h2AAA, 14'h1555, 64'hF555_0AAA_ECCC_1333, 1'b0};
        vecs[7] = '{14'h0000, 14'h3FFF, 14'h0000, 14'h3FFF, 64'h1FFF_E000_1FFF_E000, 1'b1};

        axis.TREADY = 1'b1;
        #12;
        checkOutput("reset tvalid", 64'(axis.TVALID), 64'd0);
        checkOutput("reset tdata", axis.TDATA, 64'd0);
        checkOutput("reset tlast", 64'(axis.TLAST), 64'd0);
        checkOutput("reset level", 64'(FIFO_LEVEL), 64'd0);
        checkOutput("reset overflow", 64'(OVERFLOW_COUNT), 64'd0);
        tick();
        RESET_N = 1'b1;
        ENABLE  = 1'b1;
        tick();

        // Conversion and framing: TLAST on beats 3 and 7.
        for (int i = 0; i < 8; i++) begin
            sendAndCheck($sformatf("vec%0d", i), vecs[i].c1, vecs[i].c2, vecs[i].c3, vecs[i].c4,
                         vecs[i].expData, vecs[i].expLast);
        end

        // Stall the consumer and overrun the FIFO by two samples.
        axis.TREADY = 1'b0;
        IN_CH_2_DATA = 14'h2000;
        IN_CH_3_DATA = 14'h2000;
        IN_CH_4_DATA = 14'h2000;
        IN_DATA_VALID = 1'b1;
        for (int k = 0; k < 10; k++) begin
            IN_CH_1_DATA = 14'(k);
            tick();
        end
        IN_DATA_VALID = 1'b0;
        checkOutput("full level", 64'(FIFO_LEVEL), 64'd8);
        checkOutput("full overflow", 64'(OVERFLOW_COUNT), 64'd2);
        tick();
        checkOutput("stall tvalid", 64'(axis.TVALID), 64'd1);
        checkOutput("stall head data", axis.TDATA, rampData(0));
        checkOutput("stall head last", 64'(axis.TLAST), 64'd0);

        // Full FIFO with a pop in the same cycle still drops the incoming sample.
        IN_CH_1_DATA  = 14'd10;
        IN_DATA_VALID = 1'b1;
        axis.TREADY   = 1'b1;
        tick();
        IN_DATA_VALID = 1'b0;
        checkOutput("drop+pop level", 64'(FIFO_LEVEL), 64'd7);
        checkOutput("drop+pop overflow", 64'(OVERFLOW_COUNT), 64'd3);
        for (int k = 1; k < 8; k++) begin
            checkOutput($sformatf("drain%0d data", k), axis.TDATA, rampData(k));
            checkOutput($sformatf("drain%0d last", k), 64'(axis.TLAST), 64'((k % PKT) == PKT - 1));
            tick();
        end
        checkOutput("drained tvalid", 64'(axis.TVALID), 64'd0);
        checkOutput("drained level", 64'(FIFO_LEVEL), 64'd0);

        // Disabled capture ignores input entirely.
        ENABLE = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(14'(30 + k), 14'h2000, 14'h2000, 14'h2000);
            checkOutput($sformatf("disabled%0d tvalid", k), 64'(axis.TVALID), 64'd0);
        end
        checkOutput("disabled level", 64'(FIFO_LEVEL), 64'd0);
        checkOutput("disabled overflow", 64'(OVERFLOW_COUNT), 64'd3);
        ENABLE = 1'b1;
        for (int k = 0; k < PKT; k++) begin
            sendAndCheck($sformatf("reen%0d", k), 14'(20 + k), 14'h2000, 14'h2000, 14'h2000,
                         rampData(20 + k), k == PKT - 1);
        end

        // Reset mid-packet with three beats queued.
        axis.TREADY = 1'b0;
        for (int k = 0; k < 3; k++)
            applyStimulus(14'(40 + k), 14'h2000, 14'h2000, 14'h2000);
        checkOutput("queued level", 64'(FIFO_LEVEL), 64'd3);
        checkOutput("queued tvalid", 64'(axis.TVALID), 64'd1);
        #3;
        RESET_N = 1'b0;
        #1;
        checkOutput("async reset tvalid", 64'(axis.TVALID), 64'd0);
        checkOutput("async reset level", 64'(FIFO_LEVEL), 64'd0);
        checkOutput("async reset overflow", 64'(OVERFLOW_COUNT), 64'd0);
        tick();
        tick();
        RESET_N     = 1'b1;
        axis.TREADY = 1'b1;
        tick();
        for (int k = 0; k < PKT; k++) begin
            sendAndCheck($sformatf("post%0d", k), 14'(50 + k), 14'h2000, 14'h2000, 14'h2000,
                         rampData(50 + k), k == PKT - 1);
        end
        checkOutput("post overflow", 64'(OVERFLOW_COUNT), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
